cpu_mem_loader: RTL

CPU_MEM_LOADER -- requirements
Module: cpu_mem_loader

---
 rtl/cpu_mem_loader_pkg.sv | 22 ++
 rtl/cpu_mem_loader_bank.sv | 39 +++
 rtl/cpu_mem_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_loader_pkg
// Shared constants and types for the CPU memory loader slice.
//   DEPTH  : entries per image (instruction and data)
//   WIDTH  : bits per image word
//   IDX_W  : width of the word counter that walks one image
//   state_t: loader FSM encoding
// ---------------------------------------------------------------------------
package cpu_mem_loader_pkg;

    localparam int DEPTH = 20;
    localparam int WIDTH = 16;
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_I = 2'd1,
        LOAD_D = 2'd2,
        RUN    = 2'd3
    } state_t;

endpackage

// File: rtl/cpu_mem_loader_bank.sv
// ---------------------------------------------------------------------------
// rom_image_bank
// One register-based image (instruction or data) presented to the CPU as a
// flat set of words. A single word is written per cycle when we is high.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears every entry
//   we    : write enable for this bank
//   idx   : entry to write
//   wdata : word to write
//   mem   : all DEPTH entries, registered
// ---------------------------------------------------------------------------
module rom_image_bank
    import cpu_mem_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] mem [DEPTH]
);

    // Each entry compares against idx on its own, so an idx outside the
    // image can never alias onto a real entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (idx == IDX_W'(i)) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/cpu_mem_loader.sv
// ---------------------------------------------------------------------------
// cpu_mem_loader
// Streams an instruction image followed by a data image into two register
// banks, holding the CPU in reset until both images are complete.
//   clk                      : clock, rising edge
//   rst                      : synchronous active-high reset
//   start                    : request a full load (honoured in IDLE and RUN)
//   in_valid / in_data       : incoming word stream
//   in_ready                 : high while a load is in progress
//   irom_mem0..irom_mem19    : instruction image
//   drom_mem0..drom_mem19    : data image
//   cpu_rst                  : CPU reset, low only in RUN
//   done                     : both images loaded, CPU released
// ---------------------------------------------------------------------------
module cpu_mem_loader
    import cpu_mem_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] irom_mem0,
    output logic [WIDTH-1:0] irom_mem1,
    output logic [WIDTH-1:0] irom_mem2,
    output logic [WIDTH-1:0] irom_mem3,
    output logic [WIDTH-1:0] irom_mem4,
    output logic [WIDTH-1:0] irom_mem5,
    output logic [WIDTH-1:0] irom_mem6,
    output logic [WIDTH-1:0] irom_mem7,
    output logic [WIDTH-1:0] irom_mem8,
    output logic [WIDTH-1:0] irom_mem9,
    output logic [WIDTH-1:0] irom_mem10,
    output logic [WIDTH-1:0] irom_mem11,
    output logic [WIDTH-1:0] irom_mem12,
    output logic [WIDTH-1:0] irom_mem13,
    output logic [WIDTH-1:0] irom_mem14,
    output logic [WIDTH-1:0] irom_mem15,
    output logic [WIDTH-1:0] irom_mem16,
    output logic [WIDTH-1:0] irom_mem17,
    output logic [WIDTH-1:0] irom_mem18,
    output logic [WIDTH-1:0] irom_mem19,
    output logic [WIDTH-1:0] drom_mem0,
    output logic [WIDTH-1:0] drom_mem1,
    output logic [WIDTH-1:0] drom_mem2,
    output logic [WIDTH-1:0] drom_mem3,
    output logic [WIDTH-1:0] drom_mem4,
    output logic [WIDTH-1:0] drom_mem5,
    output logic [WIDTH-1:0] drom_mem6,
    output logic [WIDTH-1:0] drom_mem7,
    output logic [WIDTH-1:0] drom_mem8,
    output logic [WIDTH-1:0] drom_mem9,
    output logic [WIDTH-1:0] drom_mem10,
    output logic [WIDTH-1:0] drom_mem11,
    output logic [WIDTH-1:0] drom_mem12,
    output logic [WIDTH-1:0] drom_mem13,
    output logic [WIDTH-1:0] drom_mem14,
    output logic [WIDTH-1:0] drom_mem15,
    output logic [WIDTH-1:0] drom_mem16,
    output logic [WIDTH-1:0] drom_mem17,
    output logic [WIDTH-1:0] drom_mem18,
    output logic [WIDTH-1:0] drom_mem19,
    output logic             cpu_rst,
    output logic             done
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             xfer;
    logic             last_word;
    logic             irom_we;
    logic             drom_we;
    logic [WIDTH-1:0] irom_img [DEPTH];
    logic [WIDTH-1:0] drom_img [DEPTH];

    // Ready depends on the registered state alone, so the handshake has no
    // combinational path from in_valid back to in_ready.
    assign in_ready  = (state == LOAD_I) || (state == LOAD_D);
    assign xfer      = in_valid && in_ready;
    assign last_word = (idx == IDX_W'(DEPTH - 1));
    assign irom_we   = xfer && (state == LOAD_I);
    assign drom_we   = xfer && (state == LOAD_D);

    // Loader FSM with word counter and registered CPU-side outputs. Start is
    // only honoured from IDLE or RUN; in the load states it is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            cpu_rst <= 1'b1;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_I;
                        idx   <= '0;
                    end
                end
                LOAD_I: begin
                    if (xfer) begin
                        if (last_word) begin
                            state <= LOAD_D;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                LOAD_D: begin
                    if (xfer) begin
                        if (last_word) begin
                            state   <= RUN;
                            idx     <= '0;
                            cpu_rst <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (start) begin
                        state   <= LOAD_I;
                        idx     <= '0;
                        cpu_rst <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    idx     <= '0;
                    cpu_rst <= 1'b1;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    rom_image_bank u_irom (
        .clk   (clk),
        .rst   (rst),
        .we    (irom_we),
        .idx   (idx),
        .wdata (in_data),
        .mem   (irom_img)
    );

    rom_image_bank u_drom (
        .clk   (clk),
        .rst   (rst),
        .we    (drom_we),
        .idx   (idx),
        .wdata (in_data),
        .mem   (drom_img)
    );

    assign irom_mem0  = irom_img[0];
    assign irom_mem1  = irom_img[1];
    assign irom_mem2  = irom_img[2];
    assign irom_mem3  = irom_img[3];
    assign irom_mem4  = irom_img[4];
    assign irom_mem5  = irom_img[5];
    assign irom_mem6  = irom_img[6];
    assign irom_mem7  = irom_img[7];
    assign irom_mem8  = irom_img[8];
    assign irom_mem9  = irom_img[9];
    assign irom_mem10 = irom_img[10];
    assign irom_mem11 = irom_img[11];
    assign irom_mem12 = irom_img[12];
    assign irom_mem13 = irom_img[13];
    assign irom_mem14 = irom_img[14];
    assign irom_mem15 = irom_img[15];
    assign irom_mem16 = irom_img[16];
    assign irom_mem17 = irom_img[17];
    assign irom_mem18 = irom_img[18];
    assign irom_mem19 = irom_img[19];

    assign drom_mem0  = drom_img[0];
    assign drom_mem1  = drom_img[1];
    assign drom_mem2  = drom_img[2];
    assign drom_mem3  = drom_img[3];
    assign drom_mem4  = drom_img[4];
    assign drom_mem5  = drom_img[5];
    assign drom_mem6  = drom_img[6];
    assign drom_mem7  = drom_img[7];
    assign drom_mem8  = drom_img[8];
    assign drom_mem9  = drom_img[9];
    assign drom_mem10 = drom_img[10];
    assign drom_mem11 = drom_img[11];
    assign drom_mem12 = drom_img[12];
    assign drom_mem13 = drom_img[13];
    assign drom_mem14 = drom_img[14];
    assign drom_mem15 = drom_img[15];
    assign drom_mem16 = drom_img[16];
    assign drom_mem17 = drom_img[17];
    assign drom_mem18 = drom_img[18];
    assign drom_mem19 = drom_img[19];

endmodule
